// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Bundle of the UART receiver's line input and word/status
//               outputs.
//               master : receiver side (takes rx, drives data/status)
//               slave  : consumer side (drives rx, observes data/status)
//               Signals: rx (serial line, idle high), data (received word),
//               valid (one-cycle frame pulse), parity_err / frame_err
//               (qualified by valid), busy (frame in progress).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx,
        output data,
        output valid,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver. The line is synchronised,
//               each bit is the 2-of-3 majority around mid-bit, and a
//               completed frame delivers data plus error flags with a
//               one-cycle valid pulse.
//               Ports: clk (clock), rst (sync active-high reset),
//               bus (uart_rx_if.master: rx in; data, valid, parity_err,
//               frame_err, busy out).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int MSB_FIRST    = 0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    uart_rx_if.master     bus
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_half  = CLKS_PER_BIT / 2;

    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_samp0   = c_cnt_w'(c_half - 1);
    localparam logic [c_cnt_w-1:0] c_samp1   = c_cnt_w'(c_half);
    localparam logic [c_cnt_w-1:0] c_dec     = c_cnt_w'(c_half + 1);
    localparam logic [3:0]         c_last    = 4'(DATA_BITS - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_par   = 3'd3;
    localparam logic [2:0] c_st_stop  = 3'd4;

    logic [1:0]           r_sync;
    logic [1:0]           r_sync_vld;   // marks when r_sync holds real line samples
    logic [2:0]           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_bitidx;
    logic                 r_armed;
    logic                 r_samp0;
    logic                 r_samp1;
    logic                 r_par_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_busy;

    logic                 w_rxs;
    logic                 w_maj;
    logic                 w_dec;
    logic                 w_xor;
    logic                 w_par_err;
    logic [DATA_BITS-1:0] w_shift_next;

    assign w_rxs = r_sync[1];
    assign w_dec = (r_cnt == c_dec);
    assign w_maj = (r_samp0 & r_samp1) | (r_samp0 & w_rxs) | (r_samp1 & w_rxs);

    // XOR over data and received parity bit: odd wants 1, even wants 0.
    assign w_xor     = (^r_shift) ^ r_par_bit;
    assign w_par_err = (PARITY == 1) ? ~w_xor :
                       (PARITY == 2) ?  w_xor : 1'b0;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shift[DATA_BITS-2:0], w_maj};
        end else begin : g_lsb_first
            assign w_shift_next = {w_maj, r_shift[DATA_BITS-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= 2'b11;
            r_sync_vld <= 2'b00;
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_bitidx   <= '0;
            r_armed    <= 1'b0;
            r_samp0    <= 1'b1;
            r_samp1    <= 1'b1;
            r_par_bit  <= 1'b0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], bus.rx};
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;

            // The reset value of the synchroniser must not arm the receiver,
            // otherwise a line stuck low from reset would start a frame.
            if (r_sync_vld[1] && w_rxs) begin
                r_armed <= 1'b1;
            end

            if (r_cnt == c_samp0) r_samp0 <= w_rxs;
            if (r_cnt == c_samp1) r_samp1 <= w_rxs;

            if (r_state != c_st_idle) begin
                r_cnt <= (r_cnt == c_cnt_max) ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    r_cnt <= '0;
                    if (r_armed && !w_rxs) begin
                        r_state <= c_st_start;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_start: begin
                    if (w_dec) begin
                        if (w_maj) begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_state  <= c_st_data;
                            r_bitidx <= '0;
                        end
                    end
                end
                c_st_data: begin
                    if (w_dec) begin
                        r_shift <= w_shift_next;
                        if (r_bitidx == c_last) begin
                            r_state <= (PARITY != 0) ? c_st_par : c_st_stop;
                        end else begin
                            r_bitidx <= r_bitidx + 1'b1;
                        end
                    end
                end
                c_st_par: begin
                    if (w_dec) begin
                        r_par_bit <= w_maj;
                        r_state   <= c_st_stop;
                    end
                end
                c_st_stop: begin
                    // Leave at mid-stop-bit so a back-to-back start edge is seen.
                    if (w_dec) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                        r_ferr  <= ~w_maj;
                        r_perr  <= w_par_err;
                        // A low stop bit disarms: a held break yields one frame.
                        r_armed <= w_maj;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.data       = r_data;
    assign bus.valid      = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire
